// File: rtl/iomem_xbar.sv
// iomem_xbar: address-decoding router from the iomem bus to N_SLAVES slaves, with timeout and unmapped default response.
// Optional IOMEM_XBAR_ERR_EN adds err / err_addr outputs flagging unmapped and timed-out accesses.
module iomem_xbar #(
  parameter int                             N_SLAVES    = 4,
  parameter int                             MATCH_BITS  = 16,
  parameter logic [N_SLAVES*MATCH_BITS-1:0] SLAVE_BASES = {16'h0303, 16'h0302, 16'h0301, 16'h0300},
  parameter int                             TIMEOUT     = 255,
  parameter logic [31:0]                    ERR_RDATA   = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iomem_valid,
  output logic                  iomem_ready,
  input  logic [31:0]           iomem_addr,
  input  logic [31:0]           iomem_wdata,
  input  logic [3:0]            iomem_wstrb,
  output logic [31:0]           iomem_rdata,
  output logic [N_SLAVES-1:0]   s_valid,
  input  logic [N_SLAVES-1:0]   s_ready,
  input  logic [32*N_SLAVES-1:0] s_rdata,
  output logic [31:0]           s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wstrb
`ifdef IOMEM_XBAR_ERR_EN
  ,
  output logic                  err,
  output logic [31:0]           err_addr
`endif
);

  localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              r_state;
  logic [IW-1:0]       r_idx;
  logic [CW-1:0]       r_cnt;
  logic [N_SLAVES-1:0] r_s_valid;
  logic                r_ready;
  logic [31:0]         r_rdata;

  logic [N_SLAVES-1:0] w_hit;
  logic                w_hit_any;
  logic [IW-1:0]       w_hit_idx;
  logic [N_SLAVES-1:0] w_hit_onehot;
  logic                w_sel_ready;
  logic [31:0]         w_sel_rdata;
  logic                w_timeout;

  generate
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_decode
      assign w_hit[gi] = (iomem_addr[31 -: MATCH_BITS] == SLAVE_BASES[gi*MATCH_BITS +: MATCH_BITS]);
    end
  endgenerate

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_hit_any = 1'b1;
        w_hit_idx = IW'(i);
      end
    end
  end

  assign w_hit_onehot = N_SLAVES'(1) << w_hit_idx;
  assign w_sel_ready  = s_ready[r_idx];
  assign w_sel_rdata  = s_rdata[r_idx*32 +: 32];
  assign w_timeout    = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_s_valid <= '0;
      r_ready   <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (iomem_valid) begin
            if (w_hit_any) begin
              r_idx     <= w_hit_idx;
              r_cnt     <= '0;
              r_s_valid <= w_hit_onehot;
              r_state   <= BUSY;
            end else begin
              r_rdata <= ERR_RDATA;
              r_ready <= 1'b1;
              r_state <= RESP;
            end
          end
        end
        BUSY: begin
          // A slave answer in the expiry cycle still wins over the timeout.
          if (w_sel_ready) begin
            r_rdata   <= w_sel_rdata;
            r_s_valid <= '0;
            r_ready   <= 1'b1;
            r_state   <= RESP;
          end else if (w_timeout) begin
            r_rdata   <= ERR_RDATA;
            r_s_valid <= '0;
            r_ready   <= 1'b1;
            r_state   <= RESP;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign s_valid     = r_s_valid;
  assign s_addr      = iomem_addr;
  assign s_wdata     = iomem_wdata;
  assign s_wstrb     = iomem_wstrb;

`ifdef IOMEM_XBAR_ERR_EN
  logic        r_err;
  logic [31:0] r_err_addr;
  logic [31:0] r_req_addr;
  logic        w_unmapped;
  logic        w_expired;

  assign w_unmapped = (r_state == IDLE) && iomem_valid && !w_hit_any;
  assign w_expired  = (r_state == BUSY) && !w_sel_ready && w_timeout;

  // The request address is latched so a timeout reports it even if the master misbehaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_req_addr <= '0;
    end else begin
      r_err <= 1'b0;
      if ((r_state == IDLE) && iomem_valid && w_hit_any) begin
        r_req_addr <= iomem_addr;
      end
      if (w_unmapped) begin
        r_err      <= 1'b1;
        r_err_addr <= iomem_addr;
      end else if (w_expired) begin
        r_err      <= 1'b1;
        r_err_addr <= r_req_addr;
      end
    end
  end

  assign err      = r_err;
  assign err_addr = r_err_addr;
`endif

endmodule
